// File: rtl/stream_pattern_gen_pkg.sv
// Shared definitions for the stream pattern generator: FSM encoding and
// pattern-mode constants.
package stream_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LGAP   = 2'd2,
        ST_FGAP   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_BYTECNT = 2'd0;
    localparam logic [1:0] MODE_XRAMP   = 2'd1;
    localparam logic [1:0] MODE_YRAMP   = 2'd2;
    localparam logic [1:0] MODE_CONST   = 2'd3;

endpackage

// File: rtl/stream_pattern_gen_if.sv
// AXI4-Stream style video bus (valid/ready, start-of-frame in tuser,
// end-of-line in tlast).
interface stream_pattern_gen_if #(
    parameter int DATA_W = 16
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/stream_pattern_gen_pix.sv
// Pixel value generator: maps the beat coordinates, running byte counter and
// constant onto tdata according to the selected pattern mode.
module stream_pattern_gen_pix
    import stream_pattern_gen_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIM_W  = 16
) (
    input  logic [1:0]        i_mode,
    input  logic [DIM_W-1:0]  i_x,
    input  logic [DIM_W-1:0]  i_y,
    input  logic [7:0]        i_byte_cnt,
    input  logic [DATA_W-1:0] i_const_val,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_x_ext;
    logic [DATA_W-1:0] w_y_ext;

    // Coordinates are zero-extended or truncated to the pixel width.
    generate
        if (DATA_W > DIM_W) begin : g_widen
            assign w_x_ext = {{(DATA_W-DIM_W){1'b0}}, i_x};
            assign w_y_ext = {{(DATA_W-DIM_W){1'b0}}, i_y};
        end else if (DATA_W == DIM_W) begin : g_same
            assign w_x_ext = i_x;
            assign w_y_ext = i_y;
        end else begin : g_narrow
            assign w_x_ext = i_x[DATA_W-1:0];
            assign w_y_ext = i_y[DATA_W-1:0];
        end
    endgenerate

    // Pattern select.
    always_comb begin
        o_data = '0;
        case (i_mode)
            MODE_BYTECNT: o_data = {(DATA_W/8){i_byte_cnt}};
            MODE_XRAMP:   o_data = w_x_ext;
            MODE_YRAMP:   o_data = w_y_ext;
            MODE_CONST:   o_data = i_const_val;
            default:      o_data = '0;
        endcase
    end

endmodule

// File: rtl/stream_pattern_gen.sv
// Video test-pattern source. Emits frames of img_width x img_height beats
// with programmable idle gaps after each line and frame. All stream outputs
// are registered: the next-cycle coordinates/config are computed
// combinationally and the pixel generator runs on those, so a stalled beat
// simply reloads identical values and stays stable.
module stream_pattern_gen
    import stream_pattern_gen_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIM_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic [1:0]           i_mode,
    input  logic [DATA_W-1:0]    i_const_val,
    input  logic [DIM_W-1:0]     i_img_width,
    input  logic [DIM_W-1:0]     i_img_height,
    input  logic [DIM_W-1:0]     i_line_space,
    input  logic [DIM_W-1:0]     i_frame_space,
    stream_pattern_gen_if.master m_axis,
    output logic [DIM_W-1:0]     o_frame_cnt,
    output logic                 o_busy
);

    localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

    state_t            r_state, w_nxt_state;
    logic [DIM_W-1:0]  r_x, w_nxt_x;
    logic [DIM_W-1:0]  r_y, w_nxt_y;
    logic [DIM_W-1:0]  r_gap, w_nxt_gap;
    logic [DIM_W-1:0]  r_frame_cnt, w_nxt_frame_cnt;
    logic [7:0]        r_byte_cnt, w_nxt_byte_cnt;

    // Configuration captured at frame start.
    logic [1:0]        r_mode, w_nxt_mode;
    logic [DATA_W-1:0] r_const, w_nxt_const;
    logic [DIM_W-1:0]  r_width, w_nxt_width;
    logic [DIM_W-1:0]  r_height, w_nxt_height;
    logic [DIM_W-1:0]  r_ls, w_nxt_ls;
    logic [DIM_W-1:0]  r_fs, w_nxt_fs;

    logic              w_accept;
    logic              w_start_ok;
    logic              w_load_cfg;
    logic              w_nxt_active;
    logic [DATA_W-1:0] w_pix;
    logic              r_busy;

    assign w_accept     = m_axis.tvalid && m_axis.tready;
    assign w_start_ok   = i_enable && (i_img_width != '0) && (i_img_height != '0);
    assign w_nxt_active = (w_nxt_state == ST_ACTIVE);
    assign o_frame_cnt  = r_frame_cnt;
    assign o_busy       = r_busy;

    // FSM state register; reset aborts any frame in progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nxt_state;
    end

    // Next-state, coordinate, counter and config-capture decisions.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_x         = r_x;
        w_nxt_y         = r_y;
        w_nxt_gap       = r_gap;
        w_nxt_frame_cnt = r_frame_cnt;
        w_nxt_byte_cnt  = r_byte_cnt;
        w_load_cfg      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_nxt_state = ST_ACTIVE;
                    w_load_cfg  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_accept) begin
                    w_nxt_byte_cnt = r_byte_cnt + 8'd1;
                    if (r_x == r_width - ONE_D) begin
                        w_nxt_x = '0;
                        if (r_y == r_height - ONE_D) begin
                            w_nxt_y         = '0;
                            w_nxt_frame_cnt = r_frame_cnt + ONE_D;
                            if (r_fs != '0) begin
                                w_nxt_state = ST_FGAP;
                                w_nxt_gap   = r_fs - ONE_D;
                            end else if (w_start_ok) begin
                                // No frame gap: next frame follows with no bubble.
                                w_nxt_state = ST_ACTIVE;
                                w_load_cfg  = 1'b1;
                            end else begin
                                w_nxt_state = ST_IDLE;
                            end
                        end else begin
                            w_nxt_y = r_y + ONE_D;
                            if (r_ls != '0) begin
                                w_nxt_state = ST_LGAP;
                                w_nxt_gap   = r_ls - ONE_D;
                            end
                        end
                    end else begin
                        w_nxt_x = r_x + ONE_D;
                    end
                end
            end
            ST_LGAP: begin
                if (r_gap == '0) w_nxt_state = ST_ACTIVE;
                else             w_nxt_gap   = r_gap - ONE_D;
            end
            ST_FGAP: begin
                if (r_gap == '0) begin
                    if (w_start_ok) begin
                        w_nxt_state = ST_ACTIVE;
                        w_load_cfg  = 1'b1;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    w_nxt_gap = r_gap - ONE_D;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase

        w_nxt_mode   = w_load_cfg ? i_mode        : r_mode;
        w_nxt_const  = w_load_cfg ? i_const_val   : r_const;
        w_nxt_width  = w_load_cfg ? i_img_width   : r_width;
        w_nxt_height = w_load_cfg ? i_img_height  : r_height;
        w_nxt_ls     = w_load_cfg ? i_line_space  : r_ls;
        w_nxt_fs     = w_load_cfg ? i_frame_space : r_fs;
    end

    stream_pattern_gen_pix #(
        .DATA_W (DATA_W),
        .DIM_W  (DIM_W)
    ) u_pix (
        .i_mode      (w_nxt_mode),
        .i_x         (w_nxt_x),
        .i_y         (w_nxt_y),
        .i_byte_cnt  (w_nxt_byte_cnt),
        .i_const_val (w_nxt_const),
        .o_data      (w_pix)
    );

    // Datapath, captured configuration and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_gap         <= '0;
            r_frame_cnt   <= '0;
            r_byte_cnt    <= '0;
            r_mode        <= '0;
            r_const       <= '0;
            r_width       <= '0;
            r_height      <= '0;
            r_ls          <= '0;
            r_fs          <= '0;
            r_busy        <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
        end else begin
            r_x           <= w_nxt_x;
            r_y           <= w_nxt_y;
            r_gap         <= w_nxt_gap;
            r_frame_cnt   <= w_nxt_frame_cnt;
            r_byte_cnt    <= w_nxt_byte_cnt;
            r_mode        <= w_nxt_mode;
            r_const       <= w_nxt_const;
            r_width       <= w_nxt_width;
            r_height      <= w_nxt_height;
            r_ls          <= w_nxt_ls;
            r_fs          <= w_nxt_fs;
            r_busy        <= (w_nxt_state != ST_IDLE);
            m_axis.tvalid <= w_nxt_active;
            m_axis.tdata  <= w_pix;
            m_axis.tuser  <= w_nxt_active && (w_nxt_x == '0) && (w_nxt_y == '0);
            m_axis.tlast  <= w_nxt_active && (w_nxt_x == w_nxt_width - ONE_D);
        end
    end

endmodule

// File: doc/stream_pattern_gen.md
STREAM_PATTERN_GEN -- requirements
Module: stream_pattern_gen

Interface
REQ-001 Parameter DATA_W, default 16, tdata width; SHALL be a multiple of 8.
REQ-002 Parameter DIM_W, default 16, width of all geometry, gap and counter ports.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  level; 1 = generate frames, 0 = stop at next frame boundary.
REQ-006 mode  input  2  pattern select: 0 byte-count, 1 x-ramp, 2 y-ramp, 3 constant.
REQ-007 const_val  input  DATA_W  pixel value for mode 3.
REQ-008 img_width, img_height  input  DIM_W each  beats per line, lines per frame.
REQ-009 line_space, frame_space  input  DIM_W each  idle cycles after each line, after each frame.
REQ-010 m_axis_tready  input  1  downstream ready.
REQ-011 m_axis_tvalid, m_axis_tuser, m_axis_tlast  output  1 each  valid, start-of-frame, end-of-line.
REQ-012 m_axis_tdata  output  DATA_W  pixel data.
REQ-013 frame_cnt  output  DIM_W  completed-frame count.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, ACTIVE, LGAP, FGAP.
REQ-016 IDLE->ACTIVE when enable=1 and latched-candidate width and height both nonzero; width or height = 0 keeps block in IDLE.
REQ-017 mode, const_val, img_width, img_height, line_space, frame_space sampled only on IDLE->ACTIVE and FGAP->ACTIVE transitions; mid-frame changes have no effect.
REQ-018 ACTIVE: tvalid=1; a beat is accepted when tvalid&tready; x increments per accepted beat.
REQ-019 While tvalid=1 and tready=0, tdata/tuser/tlast SHALL hold stable.
REQ-020 tuser=1 only on beat x=0,y=0; tlast=1 only on beat x=width-1.
REQ-021 Acceptance of tlast beat with y<height-1: x<=0, y<=y+1, to LGAP if line_space>0 else stay ACTIVE (next beat next cycle, zero bubble).
REQ-022 Acceptance of tlast beat with y=height-1: frame_cnt<=frame_cnt+1 (wraps at 2^DIM_W), x,y<=0, to FGAP if frame_space>0, else directly to the FGAP exit decision.
REQ-023 LGAP/FGAP: tvalid=0 for exactly line_space/frame_space cycles, then LGAP->ACTIVE; FGAP->ACTIVE if enable=1 and sampled dims valid, else IDLE.
REQ-024 enable deassertion mid-frame SHALL not truncate the frame; stop occurs only at frame end.
REQ-025 Mode 0: 8-bit counter increments per accepted beat across lines and frames, tdata = counter replicated DATA_W/8 times; counter cleared only by reset.
REQ-026 Mode 1: tdata = x zero-extended/truncated to DATA_W; mode 2: tdata = y likewise; mode 3: tdata = const_val.
REQ-027 Outputs registered; first beat valid the cycle after the IDLE->ACTIVE decision.
REQ-028 Throughput with tready=1 and gaps 0: one beat per cycle, no bubbles at line or frame boundaries.

Reset
REQ-029 On rst_n=0: state IDLE, tvalid/tuser/tlast/busy=0, tdata=0, frame_cnt=0, x,y,byte counter=0, sampled config=0.
REQ-030 Reset asserted mid-frame SHALL abort immediately; tvalid drops asynchronously; no partial-frame resume after release.

Structure
REQ-031 Shared package holds state encoding and mode constants (MODE_BYTECNT, MODE_XRAMP, MODE_YRAMP, MODE_CONST).
REQ-032 One sub-module, stream_pattern_gen_pix, computes tdata from mode, x, y, byte counter and const_val.

Verification
REQ-033 W=1024,H=64,LS=10,FS=20, mode 0, tready=1 -> 65536 beats/frame, tdata=={cnt,cnt} per beat, 10 idle cycles between lines, 20 after frame, frame_cnt=1.
REQ-034 Same geometry, tready low for the first 50 of every 1024 cycles -> zero data errors, tdata/tuser/tlast stable while stalled, beat count unchanged.
REQ-035 W=4,H=3,LS=0,FS=0, mode 1, tready=1 -> tdata 0,1,2,3 repeated, tlast every 4th beat, tuser on first beat only, no bubbles.
REQ-036 enable dropped at beat 5 of 12-beat frame -> frame completes, busy falls after FGAP, frame_cnt increments once.
REQ-037 img_width changed 8->16 mid-frame -> current frame keeps 8-beat lines, next frame uses 16.
REQ-038 img_height=0 with enable=1 -> tvalid stays 0, busy 0; rst_n pulsed mid-line -> all outputs 0, restart from tuser beat.
